// File: rtl/mem_stage_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pipe_reg
// Brief    : DCACHE->MEM pipeline register for an N-lane pipeline. Carries an
//            opaque per-lane payload plus the dcache read data. A per-lane
//            capture buffer keeps read data that returns while this stage is
//            held so it is not lost. Also counts held cycles (saturating).
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_pipe_reg #(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = 160,
  parameter int DATA_W    = 32,
  parameter int STALL_W   = 8,
  parameter int SELF_IDX  = 6,
  parameter int NEXT_IDX  = 7,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STALL_W-1:0]         stall,
  input  logic                       flush,
  input  logic                       cnt_clr,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES*PAYLOAD_W-1:0] in_payload,
  input  logic [LANES*DATA_W-1:0]    in_rdata,
  input  logic [LANES-1:0]           in_rdata_vld,
  output logic [LANES-1:0]           out_valid,
  output logic [LANES*PAYLOAD_W-1:0] out_payload,
  output logic [LANES*DATA_W-1:0]    out_rdata,
  output logic [LANES-1:0]           cap_vld,
  output logic [CNT_W-1:0]           stall_cycles
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stage control derived from the global stall vector
  logic w_hold;
  logic w_bubble;
  logic w_adv;

  // Only two bits of the stall vector matter here; the rest are folded away
  logic w_unused_stall;

  logic [LANES-1:0]           valid_q,   valid_d;
  logic [LANES*PAYLOAD_W-1:0] payload_q, payload_d;
  logic [LANES*DATA_W-1:0]    rdata_q,   rdata_d;
  logic [LANES-1:0]           cap_vld_q, cap_vld_d;
  logic [LANES*DATA_W-1:0]    cap_buf_q, cap_buf_d;
  logic [CNT_W-1:0]           cnt_q,     cnt_d;

  assign w_hold         = stall[SELF_IDX];
  assign w_bubble       = w_hold & ~stall[NEXT_IDX];
  assign w_adv          = ~w_hold;
  assign w_unused_stall = ^stall;

  // Next state of the output register and capture buffers (flush > bubble > adv > hold)
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    rdata_d   = rdata_q;
    cap_vld_d = cap_vld_q;
    cap_buf_d = cap_buf_q;
    if (flush) begin
      // Kill every lane; buffer contents are left alone but marked empty
      valid_d   = '0;
      payload_d = '0;
      rdata_d   = '0;
      cap_vld_d = '0;
    end else if (w_adv) begin
      // No masking by in_valid: payload and data are registered as presented
      valid_d   = in_valid;
      payload_d = in_payload;
      for (int i = 0; i < LANES; i++) begin
        rdata_d[i*DATA_W +: DATA_W] = cap_vld_q[i] ? cap_buf_q[i*DATA_W +: DATA_W]
                                                   : in_rdata[i*DATA_W +: DATA_W];
      end
      cap_vld_d = '0;
    end else begin
      // Held: downstream gets a NOP only when it is itself free to move
      if (w_bubble) begin
        valid_d   = '0;
        payload_d = '0;
        rdata_d   = '0;
      end
      // First returning beat of the stall is kept, later beats are dropped
      for (int i = 0; i < LANES; i++) begin
        if (!cap_vld_q[i] && in_rdata_vld[i]) begin
          cap_buf_d[i*DATA_W +: DATA_W] = in_rdata[i*DATA_W +: DATA_W];
          cap_vld_d[i]                  = 1'b1;
        end
      end
    end
  end

  // Next state of the saturating held-cycle counter; clear beats increment
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (w_hold && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + C_CNT_ONE;
    end
  end

  // State registers; reset also discards any pending capture
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      payload_q <= '0;
      rdata_q   <= '0;
      cap_vld_q <= '0;
      cap_buf_q <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      rdata_q   <= rdata_d;
      cap_vld_q <= cap_vld_d;
      cap_buf_q <= cap_buf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_payload  = payload_q;
  assign out_rdata    = rdata_q;
  assign cap_vld      = cap_vld_q;
  assign stall_cycles = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_pipe_reg
// Brief    : Scoreboard bench for mem_stage_pipe_reg (2 lanes, 4-bit counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_pipe_reg;

  localparam int LANES = 2;
  localparam int PW    = 160;
  localparam int DW    = 32;
  localparam int CW    = 4;

  localparam logic [PW-1:0] P0 = {20{8'h5A}};
  localparam logic [PW-1:0] P1 = {20{8'hC3}};
  localparam logic [PW-1:0] P2 = {20{8'h96}};
  localparam logic [PW-1:0] P3 = {20{8'h0F}};
  localparam logic [PW-1:0] PZ = '0;

  localparam logic [7:0] S_ADV  = 8'h00;
  localparam logic [7:0] S_HOLD = 8'hC0;
  localparam logic [7:0] S_BUB  = 8'h40;

  typedef struct packed {
    logic [LANES-1:0]    vld;
    logic [LANES*PW-1:0] pay;
    logic [LANES*DW-1:0] rd;
    logic [LANES-1:0]    cap;
    logic [CW-1:0]       cnt;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          stall;
  logic                flush;
  logic                cnt_clr;
  logic [LANES-1:0]    in_valid;
  logic [LANES*PW-1:0] in_payload;
  logic [LANES*DW-1:0] in_rdata;
  logic [LANES-1:0]    in_rdata_vld;
  logic [LANES-1:0]    out_valid;
  logic [LANES*PW-1:0] out_payload;
  logic [LANES*DW-1:0] out_rdata;
  logic [LANES-1:0]    cap_vld;
  logic [CW-1:0]       stall_cycles;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_stage_pipe_reg #(
    .LANES(LANES), .PAYLOAD_W(PW), .DATA_W(DW), .STALL_W(8),
    .SELF_IDX(6), .NEXT_IDX(7), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_payload(in_payload), .in_rdata(in_rdata),
    .in_rdata_vld(in_rdata_vld), .out_valid(out_valid), .out_payload(out_payload),
    .out_rdata(out_rdata), .cap_vld(cap_vld), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] v, input logic [PW-1:0] p1,
                              input logic [PW-1:0] p0, input logic [DW-1:0] r1,
                              input logic [DW-1:0] r0, input logic [1:0] c,
                              input logic [CW-1:0] n);
    exp_t e;
    e.vld = v; e.pay = {p1, p0}; e.rd = {r1, r0}; e.cap = c; e.cnt = n;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [LANES*PW-1:0] act,
                     input logic [LANES*PW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every cycle with an outstanding expectation is compared
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("out_valid",    {{(LANES*PW-LANES){1'b0}}, out_valid},    {{(LANES*PW-LANES){1'b0}}, e.vld});
      chk("out_payload",  out_payload,                              e.pay);
      chk("out_rdata",    {{(LANES*PW-LANES*DW){1'b0}}, out_rdata}, {{(LANES*PW-LANES*DW){1'b0}}, e.rd});
      chk("cap_vld",      {{(LANES*PW-LANES){1'b0}}, cap_vld},      {{(LANES*PW-LANES){1'b0}}, e.cap});
      chk("stall_cycles", {{(LANES*PW-CW){1'b0}}, stall_cycles},    {{(LANES*PW-CW){1'b0}}, e.cnt});
    end
  end

  task automatic drv(input logic r, input logic [7:0] s, input logic f, input logic c,
                     input logic [1:0] v, input logic [PW-1:0] p1, input logic [PW-1:0] p0,
                     input logic [DW-1:0] r1, input logic [DW-1:0] r0, input logic [1:0] rv);
    rst = r; stall = s; flush = f; cnt_clr = c; in_valid = v;
    in_payload = {p1, p0}; in_rdata = {r1, r0}; in_rdata_vld = rv;
  endtask

  task automatic cyc(input exp_t e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    // 1: reset, then one advance on lane 0
    drv(1, S_ADV, 0, 0, 2'b00, PZ, PZ, 0, 0, 2'b00);
    cyc(mk(2'b00, PZ, PZ, 0, 0, 2'b00, 0));
    cyc(mk(2'b00, PZ, PZ, 0, 0, 2'b00, 0));
    drv(0, S_ADV, 0, 0, 2'b01, PZ, P0, 32'h0, 32'h1234, 2'b01);
    cyc(mk(2'b01, PZ, P0, 32'h0, 32'h1234, 2'b00, 0));

    // 2: full hold for 3 cycles, first beat captured, second beat ignored
    drv(0, S_HOLD, 0, 0, 2'b11, P2, P1, 32'h0, 32'hDEADBEEF, 2'b01);
    cyc(mk(2'b01, PZ, P0, 32'h0, 32'h1234, 2'b01, 1));
    drv(0, S_HOLD, 0, 0, 2'b11, P2, P1, 32'h0, 32'h0, 2'b01);
    cyc(mk(2'b01, PZ, P0, 32'h0, 32'h1234, 2'b01, 2));
    drv(0, S_HOLD, 0, 0, 2'b11, P2, P1, 32'h0, 32'h0, 2'b00);
    cyc(mk(2'b01, PZ, P0, 32'h0, 32'h1234, 2'b01, 3));
    drv(0, S_ADV, 0, 0, 2'b11, P2, P1, 32'hAAAA0001, 32'h22222222, 2'b00);
    cyc(mk(2'b11, P2, P1, 32'hAAAA0001, 32'hDEADBEEF, 2'b00, 3));

    // 3: bubble with capture on lane 1, then advance (lane 0 invalid, unmasked)
    drv(0, S_BUB, 0, 0, 2'b11, P2, P1, 32'hCAFEF00D, 32'h0, 2'b10);
    cyc(mk(2'b00, PZ, PZ, 32'h0, 32'h0, 2'b10, 4));
    drv(0, S_ADV, 0, 0, 2'b10, P3, P0, 32'h0BAD0BAD, 32'h33333333, 2'b00);
    cyc(mk(2'b10, P3, P0, 32'hCAFEF00D, 32'h33333333, 2'b00, 4));

    // 4: capture on both lanes, flush while held, then advance on live data
    drv(0, S_HOLD, 0, 0, 2'b11, P1, P1, 32'h44444444, 32'h55555555, 2'b11);
    cyc(mk(2'b10, P3, P0, 32'hCAFEF00D, 32'h33333333, 2'b11, 5));
    drv(0, S_HOLD, 1, 0, 2'b11, P1, P1, 32'hEEEEEEEE, 32'hFFFFFFFF, 2'b11);
    cyc(mk(2'b00, PZ, PZ, 32'h0, 32'h0, 2'b00, 6));
    drv(0, S_ADV, 0, 0, 2'b11, P1, P2, 32'h66666666, 32'h77777777, 2'b00);
    cyc(mk(2'b11, P1, P2, 32'h66666666, 32'h77777777, 2'b00, 6));

    // 5: long hold saturates the counter at 15, clear wins over increment
    for (int i = 1; i <= 21; i++) begin
      drv(0, S_HOLD, 0, 0, 2'b00, PZ, PZ, 32'h0, 32'h0, 2'b00);
      cyc(mk(2'b11, P1, P2, 32'h66666666, 32'h77777777, 2'b00,
             CW'((6 + i > 15) ? 15 : 6 + i)));
    end
    drv(0, S_HOLD, 0, 1, 2'b00, PZ, PZ, 32'h0, 32'h0, 2'b00);
    cyc(mk(2'b11, P1, P2, 32'h66666666, 32'h77777777, 2'b00, 0));

    // Reset during a stall discards the pending capture
    drv(0, S_HOLD, 0, 0, 2'b00, PZ, PZ, 32'h0, 32'h88888888, 2'b01);
    cyc(mk(2'b11, P1, P2, 32'h66666666, 32'h77777777, 2'b01, 1));
    drv(1, S_HOLD, 0, 0, 2'b00, PZ, PZ, 32'h0, 32'h0, 2'b00);
    cyc(mk(2'b00, PZ, PZ, 32'h0, 32'h0, 2'b00, 0));
    drv(0, S_ADV, 0, 0, 2'b01, PZ, P0, 32'h0, 32'h99999999, 2'b01);
    cyc(mk(2'b01, PZ, P0, 32'h0, 32'h99999999, 2'b00, 0));

    drv(0, S_ADV, 0, 0, 2'b00, PZ, PZ, 32'h0, 32'h0, 2'b00);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
